// File: rtl/gameover_sender_pkg.sv
// Shared game-over types: result code, frame header and sender FSM states.
// The receiver on the remote board imports the same result encoding.
package gameover_sender_pkg;

  typedef enum logic [1:0] {
    GO_NONE  = 2'b00,
    GO_TOM   = 2'b01,
    GO_JERRY = 2'b10,
    GO_DRAW  = 2'b11
  } gameover_t;

  localparam logic [3:0] FRAME_HEADER = 4'hA;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic logic [7:0] frame_byte(input logic [3:0] hdr, input gameover_t code);
    return {hdr, 2'b00, code};
  endfunction

endpackage

// File: rtl/gameover_sender_encoder.sv
// Maps simultaneous game-end pulses to a result code; both at once is a draw.
module gameover_encoder
  import gameover_sender_pkg::*;
(
  input  logic      caught,
  input  logic      time_up,
  output gameover_t code
);

  always_comb begin
    case ({time_up, caught})
      2'b01:   code = GO_TOM;
      2'b10:   code = GO_JERRY;
      2'b11:   code = GO_DRAW;
      default: code = GO_NONE;
    endcase
  end

endmodule

// File: rtl/gameover_sender.sv
// Latches the local game result and sends it REPEAT times as framed bytes
// over a valid/ready link, with idle gaps between frames.
module gameover_sender
  import gameover_sender_pkg::*;
#(
  parameter int         REPEAT     = 4,
  parameter int         GAP_CYCLES = 1000,
  parameter logic [3:0] HEADER     = FRAME_HEADER
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       caught,
  input  logic       time_up,
  input  logic       restart,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [1:0] gameover,
  output logic       over,
  output logic       busy,
  output state_t     state_dbg
);

  // Valid/ready: a byte moves on a rising edge where tx_valid && tx_ready;
  // once raised, tx_valid and tx_data hold until that edge.

  localparam int REP_W = $clog2(REPEAT + 1);
  localparam int GAP_W = $clog2(GAP_CYCLES + 1);
  localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYCLES);

  state_t           state_q, state_d;
  logic [REP_W-1:0] rep_q, rep_d, rep_inc;
  logic [GAP_W-1:0] gap_q, gap_d;
  gameover_t        code_q, code_d, ev_code;
  logic             pend_q, pend_d;
  logic             go_idle;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_valid_q, tx_valid_d;
  logic             busy_q, busy_d;
  logic             over_q, over_d;

  gameover_encoder u_enc (
    .caught  (caught),
    .time_up (time_up),
    .code    (ev_code)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      rep_q      <= '0;
      gap_q      <= '0;
      code_q     <= GO_NONE;
      pend_q     <= 1'b0;
      tx_data_q  <= 8'h00;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      over_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rep_q      <= rep_d;
      gap_q      <= gap_d;
      code_q     <= code_d;
      pend_q     <= pend_d;
      tx_data_q  <= tx_data_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      over_q     <= over_d;
    end
  end

  always_comb begin
    state_d = state_q;
    rep_d   = rep_q;
    gap_d   = gap_q;
    code_d  = code_q;
    pend_d  = pend_q;
    go_idle = 1'b0;
    rep_inc = rep_q + REP_W'(1);
    case (state_q)
      ST_IDLE: begin
        if (restart) begin
          go_idle = 1'b1;
        end else if (ev_code != GO_NONE) begin
          code_d  = ev_code;
          rep_d   = '0;
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        // A restart seen mid-offer is remembered and acted on after the handshake.
        if (tx_valid_q && tx_ready) begin
          rep_d = rep_inc;
          if (pend_q || restart) begin
            go_idle = 1'b1;
          end else if (rep_inc == REP_LAST) begin
            state_d = ST_DONE;
          end else begin
            state_d = ST_GAP;
            gap_d   = '0;
          end
        end else if (restart) begin
          pend_d = 1'b1;
        end
      end
      ST_GAP: begin
        // Counting 0..GAP_CYCLES puts the next offer GAP_CYCLES+1 edges after a transfer.
        if (restart) begin
          go_idle = 1'b1;
        end else if (gap_q == GAP_LAST) begin
          state_d = ST_SEND;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end
      ST_DONE: begin
        if (restart) go_idle = 1'b1;
      end
      default: go_idle = 1'b1;
    endcase
    if (go_idle) begin
      state_d = ST_IDLE;
      rep_d   = '0;
      gap_d   = '0;
      code_d  = GO_NONE;
      pend_d  = 1'b0;
    end
  end

  always_comb begin
    tx_valid_d = (state_d == ST_SEND);
    busy_d     = (state_d == ST_SEND) || (state_d == ST_GAP);
    over_d     = (code_d != GO_NONE);
    tx_data_d  = over_d ? frame_byte(HEADER, code_d) : 8'h00;
  end

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign busy      = busy_q;
  assign over      = over_q;
  assign gameover  = code_q;
  assign state_dbg = state_q;

endmodule
